axi_ram_arbiter: RTL and testbench
==================================

# axi_ram_arbiter

Two-requester arbiter and sequencer in front of the single-beat AXI RAM. Each requester (e.g. tree-walk engine and host loader) issues simple single-word read/write commands. The block grants them round-robin, converts each command into one AXI4 single-beat transaction on its master port, and returns completion and read data to the granted requester. Exactly one transaction is outstanding at a time.

## Interface
- DATA_WIDTH, 32, data bus width (multiple of 8)
- ADDR_WIDTH, 16, address width
- ID_WIDTH, 8, AXI ID width (≥1)

- aclk  in  1  clock
- aresetn  in  1  reset, asynchronous, active-low
- reqN_valid  in  1  command valid, N∈{0,1}
- reqN_ready  out  1  command accepted (one-cycle pulse)
- reqN_wr  in  1  1 = write, 0 = read
- reqN_addr  in  ADDR_WIDTH  word address
- reqN_wdata  in  DATA_WIDTH  write data
- rspN_valid  out  1  completion pulse, one cycle, no backpressure
- rspN_rdata  out  DATA_WIDTH  read data; valid with rspN_valid on reads
- rspN_err  out  1  rresp≠OKAY on a read; always 0 on writes
- m_axi_aw{id,addr,valid} / awready  out/in  ID_WIDTH, ADDR_WIDTH, 1 / 1  write address channel
- m_axi_w{data,strb,last,valid} / wready  out/in  DATA_WIDTH, DATA_WIDTH/8, 1, 1 / 1  write data channel
- m_axi_bid, bresp, bvalid  in  ID_WIDTH, 2, 1  ignored; m_axi_bready out 1, tied 1
- m_axi_ar{id,addr,valid} / arready  out/in  ID_WIDTH, ADDR_WIDTH, 1 / 1  read address channel
- m_axi_r{id,data,resp,last,valid}  in  ID_WIDTH, DATA_WIDTH, 2, 1, 1; m_axi_rready out 1
- m_axi_{aw,ar}{len,size,burst,lock,cache,prot}  out  8,3,2,1,4,3  constants: len=0, size=log2(DATA_WIDTH/8), burst=INCR (2'b01), lock/cache/prot=0

## Operation
- FSM states: IDLE, WR, AR, R, RSP.
- IDLE: if any reqN_valid, choose a winner. If both are valid, grant the one not granted last; the last-grant pointer resets to 1, so requester 0 wins first.
  - Pulse winner's reqN_ready.
  - Latch wr, addr, wdata and grant index.
  - Go to WR (write) or AR (read).
- WR: assert awvalid and wvalid together from the first WR cycle.
  - Each valid drops independently after its own handshake.
  - Leave to RSP in the cycle after both handshakes have completed (same cycle allowed).
  - B channel is not awaited; bready is held at 1 and B is discarded.
- AR: assert arvalid until arready, then go to R.
- R: rready=1. On rvalid, capture rdata and (rresp≠0) into err, then go to RSP.
- RSP: one-cycle rspN_valid to the granted requester, then IDLE.
- awid/arid = grant index, zero-extended. wstrb all ones; wlast=1.
- Loser's reqN_valid stays pending: no ready while busy. It is granted on the next IDLE.
- reqN_ready is only asserted in IDLE. Commands presented mid-transaction wait.
- rspN_rdata holds its last captured value until the next read completes for that requester.

## Timing
- Reset values: all *valid/ready outputs 0 (bready 1), rspN_rdata 0, rspN_err 0, state IDLE, last-grant 1.
- Reset mid-transaction aborts immediately: AXI valids drop asynchronously, no rsp emitted.
- Command accepted at cycle T, with awready=wready=arready=1 and RAM read latency 1:
  - write: AW/W handshake T+1, rsp T+2, next accept T+3.
  - read: AR T+1, rvalid T+2, rsp T+3, next accept T+4.
- awready/wready stalls extend WR cycle-for-cycle. arready low holds AR.
- No combinational path from requester inputs to AXI outputs; all AXI outputs are registered.

## Test plan
- Single write: req0 wr addr 0x5 data 0xDEADBEEF at T → awvalid/wvalid with awaddr 0x5, awid 0 at T+1; rsp0_valid at T+2, rsp0_err 0.
- Read-back: req1 read addr 0x5 → arid 1 at T+1; rsp1_valid at T+3 with rsp1_rdata 0xDEADBEEF.
- Contention: req0 and req1 both valid from reset with reads of 0x1 and 0x2 → grant order 0,1,0,1. Each rsp goes only to its owner; neither starves.
- Split handshake: wready low 3 cycles after awready → awvalid drops after its handshake, wvalid held; rsp0 fires the cycle after the W handshake.
- Read error: slave returns rresp=2'b10 → rspN_err=1 with rsp pulse; next read with OKAY returns err=0.
- Async reset in R state: aresetn low → all valids 0 without a clock edge; no rsp; after release, first new command completes normally.

Source files
------------

// File: rtl/axi_ram_arbiter.sv
// rtl/axi_ram_arbiter.sv - two-requester round-robin arbiter and single-beat AXI4 sequencer
//
// Purpose:
//   Accepts simple single-word read/write commands from two requesters,
//   grants them round-robin, issues one single-beat AXI4 transaction at a
//   time on the master port and returns a one-cycle completion pulse (plus
//   read data and error flag) to the requester that owned the transaction.
//
// Ports:
//   aclk, aresetn          clock, asynchronous active-low reset
//   reqN_*                 command inputs (valid/wr/addr/wdata), reqN_ready accept pulse
//   rspN_*                 completion pulse, read data (held), read error flag
//   m_axi_aw*/w*/b*        AXI4 write channels (B is accepted and discarded)
//   m_axi_ar*/r*           AXI4 read channels
module axi_ram_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 16,
  parameter int ID_WIDTH   = 8
) (
  input  logic                    aclk,
  input  logic                    aresetn,

  input  logic                    req0_valid,
  output logic                    req0_ready,
  input  logic                    req0_wr,
  input  logic [ADDR_WIDTH-1:0]   req0_addr,
  input  logic [DATA_WIDTH-1:0]   req0_wdata,
  output logic                    rsp0_valid,
  output logic [DATA_WIDTH-1:0]   rsp0_rdata,
  output logic                    rsp0_err,

  input  logic                    req1_valid,
  output logic                    req1_ready,
  input  logic                    req1_wr,
  input  logic [ADDR_WIDTH-1:0]   req1_addr,
  input  logic [DATA_WIDTH-1:0]   req1_wdata,
  output logic                    rsp1_valid,
  output logic [DATA_WIDTH-1:0]   rsp1_rdata,
  output logic                    rsp1_err,

  output logic [ID_WIDTH-1:0]     m_axi_awid,
  output logic [ADDR_WIDTH-1:0]   m_axi_awaddr,
  output logic [7:0]              m_axi_awlen,
  output logic [2:0]              m_axi_awsize,
  output logic [1:0]              m_axi_awburst,
  output logic                    m_axi_awlock,
  output logic [3:0]              m_axi_awcache,
  output logic [2:0]              m_axi_awprot,
  output logic                    m_axi_awvalid,
  input  logic                    m_axi_awready,

  output logic [DATA_WIDTH-1:0]   m_axi_wdata,
  output logic [DATA_WIDTH/8-1:0] m_axi_wstrb,
  output logic                    m_axi_wlast,
  output logic                    m_axi_wvalid,
  input  logic                    m_axi_wready,

  input  logic [ID_WIDTH-1:0]     m_axi_bid,
  input  logic [1:0]              m_axi_bresp,
  input  logic                    m_axi_bvalid,
  output logic                    m_axi_bready,

  output logic [ID_WIDTH-1:0]     m_axi_arid,
  output logic [ADDR_WIDTH-1:0]   m_axi_araddr,
  output logic [7:0]              m_axi_arlen,
  output logic [2:0]              m_axi_arsize,
  output logic [1:0]              m_axi_arburst,
  output logic                    m_axi_arlock,
  output logic [3:0]              m_axi_arcache,
  output logic [2:0]              m_axi_arprot,
  output logic                    m_axi_arvalid,
  input  logic                    m_axi_arready,

  input  logic [ID_WIDTH-1:0]     m_axi_rid,
  input  logic [DATA_WIDTH-1:0]   m_axi_rdata,
  input  logic [1:0]              m_axi_rresp,
  input  logic                    m_axi_rlast,
  input  logic                    m_axi_rvalid,
  output logic                    m_axi_rready
);

  localparam logic [2:0] AXSIZE = 3'($clog2(DATA_WIDTH / 8));

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR,
    S_AR,
    S_R,
    S_RSP
  } state_t;

  state_t                  state_q;
  logic                    last_q;
  logic                    gnt_q;
  logic [ID_WIDTH-1:0]     id_q;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [DATA_WIDTH-1:0]   wdata_q;
  logic                    awvalid_q;
  logic                    wvalid_q;
  logic                    arvalid_q;
  logic                    rready_q;
  logic [1:0]              rsp_valid_q;
  logic [1:0]              err_q;
  logic [DATA_WIDTH-1:0]   rdata0_q;
  logic [DATA_WIDTH-1:0]   rdata1_q;

  logic                    win_d;
  logic                    any_req;
  logic                    sel_wr;
  logic [ADDR_WIDTH-1:0]   sel_addr;
  logic [DATA_WIDTH-1:0]   sel_wdata;
  logic                    wr_done;

  // B channel and R sideband are not needed: one transaction in flight.
  logic unused_inputs;
  assign unused_inputs = ^{m_axi_bid, m_axi_bresp, m_axi_bvalid, m_axi_rid, m_axi_rlast};

  // Round-robin: with both pending, the one not granted last wins.
  always_comb begin
    win_d = 1'b0;
    if (req0_valid && req1_valid) begin
      win_d = ~last_q;
    end else begin
      win_d = ~req0_valid;
    end
  end

  assign any_req   = req0_valid | req1_valid;
  assign sel_wr    = win_d ? req1_wr    : req0_wr;
  assign sel_addr  = win_d ? req1_addr  : req0_addr;
  assign sel_wdata = win_d ? req1_wdata : req0_wdata;

  // Ready is gated by reset so it is low while aresetn is asserted.
  assign req0_ready = aresetn && (state_q == S_IDLE) && req0_valid && !win_d;
  assign req1_ready = aresetn && (state_q == S_IDLE) && req1_valid &&  win_d;

  // A channel is done once its valid has dropped or handshakes this cycle.
  assign wr_done = (!awvalid_q || m_axi_awready) && (!wvalid_q || m_axi_wready);

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q     <= S_IDLE;
      last_q      <= 1'b1;
      gnt_q       <= 1'b0;
      id_q        <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      awvalid_q   <= 1'b0;
      wvalid_q    <= 1'b0;
      arvalid_q   <= 1'b0;
      rready_q    <= 1'b0;
      rsp_valid_q <= 2'b00;
      err_q       <= 2'b00;
      rdata0_q    <= '0;
      rdata1_q    <= '0;
    end else begin
      rsp_valid_q <= 2'b00;
      case (state_q)
        S_IDLE: begin
          if (any_req) begin
            gnt_q   <= win_d;
            last_q  <= win_d;
            id_q    <= ID_WIDTH'(win_d);
            addr_q  <= sel_addr;
            wdata_q <= sel_wdata;
            if (sel_wr) begin
              awvalid_q <= 1'b1;
              wvalid_q  <= 1'b1;
              state_q   <= S_WR;
            end else begin
              arvalid_q <= 1'b1;
              state_q   <= S_AR;
            end
          end
        end
        S_WR: begin
          if (awvalid_q && m_axi_awready) awvalid_q <= 1'b0;
          if (wvalid_q && m_axi_wready)   wvalid_q  <= 1'b0;
          if (wr_done) begin
            rsp_valid_q[gnt_q] <= 1'b1;
            err_q[gnt_q]       <= 1'b0;
            state_q            <= S_RSP;
          end
        end
        S_AR: begin
          if (m_axi_arready) begin
            arvalid_q <= 1'b0;
            rready_q  <= 1'b1;
            state_q   <= S_R;
          end
        end
        S_R: begin
          if (m_axi_rvalid) begin
            rready_q           <= 1'b0;
            rsp_valid_q[gnt_q] <= 1'b1;
            err_q[gnt_q]       <= (m_axi_rresp != 2'b00);
            if (gnt_q) rdata1_q <= m_axi_rdata;
            else       rdata0_q <= m_axi_rdata;
            state_q            <= S_RSP;
          end
        end
        S_RSP: begin
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign rsp0_valid = rsp_valid_q[0];
  assign rsp1_valid = rsp_valid_q[1];
  assign rsp0_rdata = rdata0_q;
  assign rsp1_rdata = rdata1_q;
  assign rsp0_err   = err_q[0];
  assign rsp1_err   = err_q[1];

  assign m_axi_awid    = id_q;
  assign m_axi_awaddr  = addr_q;
  assign m_axi_awlen   = 8'd0;
  assign m_axi_awsize  = AXSIZE;
  assign m_axi_awburst = 2'b01;
  assign m_axi_awlock  = 1'b0;
  assign m_axi_awcache = 4'd0;
  assign m_axi_awprot  = 3'd0;
  assign m_axi_awvalid = awvalid_q;

  assign m_axi_wdata   = wdata_q;
  assign m_axi_wstrb   = '1;
  assign m_axi_wlast   = 1'b1;
  assign m_axi_wvalid  = wvalid_q;

  assign m_axi_bready  = 1'b1;

  assign m_axi_arid    = id_q;
  assign m_axi_araddr  = addr_q;
  assign m_axi_arlen   = 8'd0;
  assign m_axi_arsize  = AXSIZE;
  assign m_axi_arburst = 2'b01;
  assign m_axi_arlock  = 1'b0;
  assign m_axi_arcache = 4'd0;
  assign m_axi_arprot  = 3'd0;
  assign m_axi_arvalid = arvalid_q;

  assign m_axi_rready  = rready_q;

endmodule

// File: tb/tb_axi_ram_arbiter.sv
// tb/tb_axi_ram_arbiter.sv - directed self-checking bench for axi_ram_arbiter
module tb_axi_ram_arbiter;

  logic        aclk = 1'b0;
  logic        aresetn;
  logic        req0_valid, req0_ready, req0_wr;
  logic [15:0] req0_addr;
  logic [31:0] req0_wdata;
  logic        rsp0_valid, rsp0_err;
  logic [31:0] rsp0_rdata;
  logic        req1_valid, req1_ready, req1_wr;
  logic [15:0] req1_addr;
  logic [31:0] req1_wdata;
  logic        rsp1_valid, rsp1_err;
  logic [31:0] rsp1_rdata;

  logic [7:0]  awid, arid;
  logic [15:0] awaddr, araddr;
  logic [7:0]  awlen, arlen;
  logic [2:0]  awsize, arsize, awprot, arprot;
  logic [1:0]  awburst, arburst;
  logic        awlock, arlock;
  logic [3:0]  awcache, arcache;
  logic        awvalid, wvalid, wlast, bready, arvalid, rready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;

  logic        s_awready, s_wready, s_arready;
  logic        s_rvalid;
  logic [31:0] s_rdata;
  logic [1:0]  s_rresp;
  logic [1:0]  rresp_cfg;
  logic        r_hold;

  logic [31:0]  mem [256];
  logic [255:0] written = '0;

  int vectors = 0;
  int miscompares = 0;

  always #5 aclk = ~aclk;

  axi_ram_arbiter #(.DATA_WIDTH(32), .ADDR_WIDTH(16), .ID_WIDTH(8)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_wr(req0_wr),
    .req0_addr(req0_addr), .req0_wdata(req0_wdata),
    .rsp0_valid(rsp0_valid), .rsp0_rdata(rsp0_rdata), .rsp0_err(rsp0_err),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_wr(req1_wr),
    .req1_addr(req1_addr), .req1_wdata(req1_wdata),
    .rsp1_valid(rsp1_valid), .rsp1_rdata(rsp1_rdata), .rsp1_err(rsp1_err),
    .m_axi_awid(awid), .m_axi_awaddr(awaddr), .m_axi_awlen(awlen),
    .m_axi_awsize(awsize), .m_axi_awburst(awburst), .m_axi_awlock(awlock),
    .m_axi_awcache(awcache), .m_axi_awprot(awprot), .m_axi_awvalid(awvalid),
    .m_axi_awready(s_awready),
    .m_axi_wdata(wdata), .m_axi_wstrb(wstrb), .m_axi_wlast(wlast),
    .m_axi_wvalid(wvalid), .m_axi_wready(s_wready),
    .m_axi_bid(8'd0), .m_axi_bresp(2'b00), .m_axi_bvalid(1'b0), .m_axi_bready(bready),
    .m_axi_arid(arid), .m_axi_araddr(araddr), .m_axi_arlen(arlen),
    .m_axi_arsize(arsize), .m_axi_arburst(arburst), .m_axi_arlock(arlock),
    .m_axi_arcache(arcache), .m_axi_arprot(arprot), .m_axi_arvalid(arvalid),
    .m_axi_arready(s_arready),
    .m_axi_rid(8'd0), .m_axi_rdata(s_rdata), .m_axi_rresp(s_rresp),
    .m_axi_rlast(1'b1), .m_axi_rvalid(s_rvalid), .m_axi_rready(rready)
  );

  // RAM slave: read latency 1; unwritten words read as {16'hC0DE, addr}.
  always @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      s_rvalid <= 1'b0;
      s_rdata  <= '0;
      s_rresp  <= 2'b00;
    end else begin
      if (wvalid && s_wready) begin
        mem[awaddr[7:0]]     <= wdata;
        written[awaddr[7:0]] <= 1'b1;
      end
      if (s_rvalid && rready) s_rvalid <= 1'b0;
      if (arvalid && s_arready && !r_hold) begin
        s_rvalid <= 1'b1;
        s_rdata  <= written[araddr[7:0]] ? mem[araddr[7:0]] : {16'hC0DE, araddr};
        s_rresp  <= rresp_cfg;
      end
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic run_cmd(input int n, input logic wr, input logic [15:0] a, input logic [31:0] d,
                         output logic [31:0] rd, output logic er, output int lat);
    int k;
    logic rdy, rv, other;
    if (n == 0) begin
      req0_valid = 1'b1; req0_wr = wr; req0_addr = a; req0_wdata = d;
    end else begin
      req1_valid = 1'b1; req1_wr = wr; req1_addr = a; req1_wdata = d;
    end
    k = 0;
    @(negedge aclk);
    rdy = (n == 0) ? req0_ready : req1_ready;
    while (!rdy && k < 20) begin
      @(negedge aclk);
      k++;
      rdy = (n == 0) ? req0_ready : req1_ready;
    end
    check("accept", rdy, 1);
    @(posedge aclk);
    #1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    lat = 0;
    rv  = 1'b0;
    while (!rv && lat < 20) begin
      @(negedge aclk);
      lat++;
      rv    = (n == 0) ? rsp0_valid : rsp1_valid;
      other = (n == 0) ? rsp1_valid : rsp0_valid;
    end
    check("rsp_seen", rv, 1);
    check("rsp_owner_only", other, 0);
    rd = (n == 0) ? rsp0_rdata : rsp1_rdata;
    er = (n == 0) ? rsp0_err : rsp1_err;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;
    logic        er;
    int          lat;
    int          g[4];
    int          ro[4];
    int          ngr, nrs;
    logic        dropped;

    aresetn = 1'b0;
    req0_valid = 0; req0_wr = 0; req0_addr = 0; req0_wdata = 0;
    req1_valid = 0; req1_wr = 0; req1_addr = 0; req1_wdata = 0;
    s_awready = 1; s_wready = 1; s_arready = 1;
    rresp_cfg = 2'b00; r_hold = 0;

    // Reset state
    repeat (3) tick();
    req0_valid = 1'b1;
    #1;
    check("rst_req0_ready", req0_ready, 0);
    check("rst_awvalid", awvalid, 0);
    check("rst_wvalid", wvalid, 0);
    check("rst_arvalid", arvalid, 0);
    check("rst_rready", rready, 0);
    check("rst_bready", bready, 1);
    check("rst_rsp0", {rsp0_valid, rsp0_err, rsp0_rdata}, 0);
    req0_valid = 1'b0;
    tick();
    aresetn = 1'b1;
    tick();

    // Single write: req0 wr 0x5 <- 0xDEADBEEF
    req0_valid = 1; req0_wr = 1; req0_addr = 16'h5; req0_wdata = 32'hDEADBEEF;
    @(negedge aclk);
    check("w_req0_ready", req0_ready, 1);
    check("w_req1_ready", req1_ready, 0);
    tick();
    req0_valid = 0;
    check("w_awvalid", awvalid, 1);
    check("w_wvalid", wvalid, 1);
    check("w_awaddr", awaddr, 16'h5);
    check("w_awid", awid, 0);
    check("w_wdata", wdata, 32'hDEADBEEF);
    check("w_wstrb_wlast", {wstrb, wlast}, 5'b11111);
    check("w_awsize_burst_len", {awsize, awburst, awlen}, {3'd2, 2'b01, 8'd0});
    tick();
    check("w_rsp0_valid", rsp0_valid, 1);
    check("w_rsp0_err", rsp0_err, 0);
    check("w_rsp1_quiet", rsp1_valid, 0);
    check("w_aw_dropped", {awvalid, wvalid}, 0);
    tick();
    check("w_rsp0_pulse", rsp0_valid, 0);

    // Read-back by req1
    req1_valid = 1; req1_wr = 0; req1_addr = 16'h5;
    @(negedge aclk);
    check("r_req1_ready", req1_ready, 1);
    tick();
    req1_valid = 0;
    check("r_arvalid", arvalid, 1);
    check("r_arid", arid, 1);
    check("r_araddr", araddr, 16'h5);
    check("r_arsize", {arsize, arburst, arlen}, {3'd2, 2'b01, 8'd0});
    tick();
    check("r_rready", rready, 1);
    check("r_rsp1_early", rsp1_valid, 0);
    tick();
    check("r_rsp1_valid", rsp1_valid, 1);
    check("r_rsp1_rdata", rsp1_rdata, 32'hDEADBEEF);
    check("r_rsp1_err", rsp1_err, 0);
    check("r_rsp0_quiet", rsp0_valid, 0);
    tick();

    // Split handshake: AW accepted, W stalled 3 cycles
    s_wready = 0;
    req0_valid = 1; req0_wr = 1; req0_addr = 16'h7; req0_wdata = 32'h12345678;
    @(negedge aclk);
    check("s_req0_ready", req0_ready, 1);
    tick();
    req0_valid = 0;
    check("s_both_valid", {awvalid, wvalid}, 2'b11);
    tick();
    check("s_aw_dropped", {awvalid, wvalid}, 2'b01);
    tick();
    check("s_w_held", {wvalid, rsp0_valid}, 2'b10);
    tick();
    check("s_w_held2", {wvalid, rsp0_valid}, 2'b10);
    s_wready = 1;
    tick();
    check("s_rsp0_valid", rsp0_valid, 1);
    check("s_w_dropped", wvalid, 0);
    tick();

    // Read error then OKAY
    rresp_cfg = 2'b10;
    run_cmd(0, 1'b0, 16'h7, 32'h0, rd, er, lat);
    check("e_lat", lat, 3);
    check("e_err", er, 1);
    check("e_rdata", rd, 32'h12345678);
    rresp_cfg = 2'b00;
    run_cmd(0, 1'b0, 16'h7, 32'h0, rd, er, lat);
    check("e_ok_err", er, 0);
    check("e_rsp1_held", rsp1_rdata, 32'hDEADBEEF);

    // Write latency via req1 and read-back
    run_cmd(1, 1'b1, 16'h9, 32'hCAFEF00D, rd, er, lat);
    check("w2_lat", lat, 2);
    check("w2_err", er, 0);
    run_cmd(1, 1'b0, 16'h9, 32'h0, rd, er, lat);
    check("w2_rdata", rd, 32'hCAFEF00D);

    // Contention from reset: both read continuously
    aresetn = 0;
    req0_valid = 1; req0_wr = 0; req0_addr = 16'h1;
    req1_valid = 1; req1_wr = 0; req1_addr = 16'h2;
    #1;
    check("c_rst_rsp1_rdata", rsp1_rdata, 0);
    check("c_rst_ready", {req0_ready, req1_ready}, 0);
    tick();
    tick();
    aresetn = 1;
    ngr = 0; nrs = 0; dropped = 0;
    for (int c = 0; c < 60 && nrs < 4; c++) begin
      @(negedge aclk);
      if (req0_ready && req1_ready) check("c_dual_ready", 1, 0);
      if (rsp0_valid && rsp1_valid) check("c_dual_rsp", 1, 0);
      if (ngr < 4 && req0_ready) begin g[ngr] = 0; ngr++; end
      if (ngr < 4 && req1_ready) begin g[ngr] = 1; ngr++; end
      if (rsp0_valid && nrs < 4) begin
        ro[nrs] = 0; nrs++;
        check("c_rsp0_rdata", rsp0_rdata, 32'hC0DE0001);
      end
      if (rsp1_valid && nrs < 4) begin
        ro[nrs] = 1; nrs++;
        check("c_rsp1_rdata", rsp1_rdata, 32'hC0DE0002);
      end
      if (ngr == 4 && !dropped) begin
        @(posedge aclk);
        #1;
        req0_valid = 0;
        req1_valid = 0;
        dropped = 1;
      end
    end
    check("c_grants", ngr, 4);
    check("c_rsps", nrs, 4);
    check("c_order", {g[0][1:0], g[1][1:0], g[2][1:0], g[3][1:0]}, 8'b00_01_00_01);
    check("c_rsp_order", {ro[0][1:0], ro[1][1:0], ro[2][1:0], ro[3][1:0]}, 8'b00_01_00_01);
    tick();

    // Asynchronous reset while waiting in R
    r_hold = 1;
    req1_valid = 1; req1_wr = 0; req1_addr = 16'h5;
    @(negedge aclk);
    check("a_req1_ready", req1_ready, 1);
    tick();
    req1_valid = 0;
    tick();
    check("a_in_r", {rready, arvalid}, 2'b10);
    #2;
    aresetn = 0;
    #1;
    check("a_valids_low", {awvalid, wvalid, arvalid, rready}, 0);
    check("a_rsp_low", {rsp0_valid, rsp1_valid}, 0);
    for (int i = 0; i < 2; i++) begin
      @(negedge aclk);
      check("a_no_rsp", {rsp0_valid, rsp1_valid}, 0);
    end
    @(posedge aclk);
    #1;
    aresetn = 1;
    r_hold = 0;
    run_cmd(1, 1'b0, 16'h5, 32'h0, rd, er, lat);
    check("a_post_lat", lat, 3);
    check("a_post_rdata", rd, 32'hDEADBEEF);
    check("a_post_err", er, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
